// File: rtl/nco_pkg.sv
// nco_pkg: shared widths, FSM state and quadrant encodings for the
// phase-to-sine receive stage, plus the quadrant-symmetry helpers used to
// fold an 8-bit phase word onto the quarter-wave ROM.
package nco_pkg;

    localparam int unsigned PHASE_W = 8;
    localparam int unsigned CHUNK_W = 2;
    localparam int unsigned AMP_W   = 8;
    localparam int unsigned BEATS   = PHASE_W / CHUNK_W;
    localparam int unsigned IDX_W   = PHASE_W - 2;

    // Quarter-turn offset turning the sine lookup into a cosine lookup.
    localparam logic [PHASE_W-1:0] COS_OFFSET = 8'h40;

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quadrant_t;

    // Odd quadrants run the quarter wave backwards.
    function automatic logic [IDX_W-1:0] rom_addr(input logic [PHASE_W-1:0] phase);
        quadrant_t q;
        q = quadrant_t'(phase[PHASE_W-1 -: 2]);
        if (q == Q1 || q == Q3)
            return ~phase[IDX_W-1:0];
        else
            return phase[IDX_W-1:0];
    endfunction

    // The second half-turn is the negated first half-turn.
    function automatic logic is_negative(input logic [PHASE_W-1:0] phase);
        quadrant_t q;
        q = quadrant_t'(phase[PHASE_W-1 -: 2]);
        return (q == Q2 || q == Q3);
    endfunction

endpackage

// File: rtl/quarter_sine_rom.sv
// quarter_sine_rom: 64-entry quarter-wave sine table with registered read.
// Entry k = round(127 * sin(2*pi*(k+0.5)/256)), unsigned, range 2..127.
// Ports:
//   clk    in   rising-edge clock
//   addr_a in   IDX_W   read address, port A
//   data_a out  AMP_W   registered data, port A
//   addr_b in   IDX_W   read address, port B (NCO_COS_OUT_EN only)
//   data_b out  AMP_W   registered data, port B (NCO_COS_OUT_EN only)
// Macro: NCO_COS_OUT_EN adds the second read port.
module quarter_sine_rom
    import nco_pkg::*;
(
    input  logic             clk,
    input  logic [IDX_W-1:0] addr_a,
    output logic [AMP_W-1:0] data_a
`ifdef NCO_COS_OUT_EN
    ,
    input  logic [IDX_W-1:0] addr_b,
    output logic [AMP_W-1:0] data_b
`endif
);

    localparam logic [AMP_W-1:0] SINE_LUT [64] = '{
          8'd2,   8'd5,   8'd8,  8'd11,  8'd14,  8'd17,  8'd20,  8'd23,
         8'd26,  8'd29,  8'd32,  8'd35,  8'd38,  8'd41,  8'd44,  8'd47,
         8'd50,  8'd53,  8'd56,  8'd58,  8'd61,  8'd64,  8'd67,  8'd69,
         8'd72,  8'd74,  8'd77,  8'd79,  8'd82,  8'd84,  8'd86,  8'd89,
         8'd91,  8'd93,  8'd95,  8'd97,  8'd99, 8'd101, 8'd103, 8'd105,
        8'd106, 8'd108, 8'd110, 8'd111, 8'd113, 8'd114, 8'd115, 8'd117,
        8'd118, 8'd119, 8'd120, 8'd121, 8'd122, 8'd123, 8'd124, 8'd124,
        8'd125, 8'd125, 8'd126, 8'd126, 8'd127, 8'd127, 8'd127, 8'd127
    };

    always_ff @(posedge clk) begin
        data_a <= SINE_LUT[addr_a];
    end

`ifdef NCO_COS_OUT_EN
    always_ff @(posedge clk) begin
        data_b <= SINE_LUT[addr_b];
    end
`endif

endmodule

// File: rtl/nco_phase_to_sine.sv
// nco_phase_to_sine: deserializes 2-bit phase beats (MSB chunk first, word
// start marked by ISin) into an 8-bit phase word and converts it to a signed
// sine sample via a quarter-wave ROM and quadrant symmetry.
// Pipeline: word complete at edge N, ROM read at N+1, Dout/Dvld at N+2.
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   synchronous active-low reset
//   En     in   block enable; low discards the partial word and flushes
//   Vld    in   beat qualifier
//   Ain    in   CHUNK_W  phase chunk
//   ISin   in   start-of-word marker (with Vld)
//   Dout   out  AMP_W    signed sine sample, holds between strobes
//   Dvld   out  one-cycle strobe, Dout is new
//   Err    out  one-cycle framing-error strobe
//   Cout   out  AMP_W    signed cosine sample (NCO_COS_OUT_EN only)
// Macro: NCO_COS_OUT_EN adds Cout and the second ROM read.
module nco_phase_to_sine
    import nco_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               En,
    input  logic               Vld,
    input  logic [CHUNK_W-1:0] Ain,
    input  logic               ISin,
    output logic [AMP_W-1:0]   Dout,
    output logic               Dvld,
    output logic               Err
`ifdef NCO_COS_OUT_EN
    ,
    output logic [AMP_W-1:0]   Cout
`endif
);

    state_t             state;
    logic [1:0]         cnt;
    logic [PHASE_W-1:0] shreg;
    logic [PHASE_W-1:0] merged;
    logic               last_beat;

    logic               req_vld;
    logic [PHASE_W-1:0] req_phase;
    logic               rd_vld;
    logic               rd_neg;
    logic [AMP_W-1:0]   rom_sin;

    // Word in progress with the current beat dropped into its slot.
    always_comb begin
        merged = shreg;
        for (int unsigned b = 0; b < BEATS; b++) begin
            if (cnt == 2'(b))
                merged[PHASE_W-1-b*CHUNK_W -: CHUNK_W] = Ain;
        end
    end

    assign last_beat = (cnt == 2'(BEATS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            shreg     <= '0;
            req_vld   <= 1'b0;
            req_phase <= '0;
            Err       <= 1'b0;
        end else if (!En) begin
            state   <= IDLE;
            cnt     <= '0;
            req_vld <= 1'b0;
            Err     <= 1'b0;
        end else begin
            req_vld <= 1'b0;
            Err     <= 1'b0;
            if (Vld) begin
                if (ISin) begin
                    // Start or restart; a restart abandons the partial word.
                    shreg <= {Ain, {(PHASE_W-CHUNK_W){1'b0}}};
                    cnt   <= 2'd1;
                    state <= COLLECT;
                    Err   <= (state == COLLECT);
                end else if (state == IDLE) begin
                    Err <= 1'b1;
                end else if (last_beat) begin
                    req_vld   <= 1'b1;
                    req_phase <= merged;
                    cnt       <= '0;
                    state     <= IDLE;
                end else begin
                    shreg <= merged;
                    cnt   <= cnt + 2'd1;
                end
            end
        end
    end

`ifdef NCO_COS_OUT_EN
    logic [PHASE_W-1:0] cos_phase;
    logic               rd_cneg;
    logic [AMP_W-1:0]   rom_cos;

    assign cos_phase = req_phase + COS_OFFSET;

    quarter_sine_rom u_rom (
        .clk    (clk),
        .addr_a (rom_addr(req_phase)),
        .data_a (rom_sin),
        .addr_b (rom_addr(cos_phase)),
        .data_b (rom_cos)
    );
`else
    quarter_sine_rom u_rom (
        .clk    (clk),
        .addr_a (rom_addr(req_phase)),
        .data_a (rom_sin)
    );
`endif

    // Sign flags travel alongside the ROM read so they line up with its data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_vld <= 1'b0;
            rd_neg <= 1'b0;
`ifdef NCO_COS_OUT_EN
            rd_cneg <= 1'b0;
`endif
        end else if (!En) begin
            rd_vld <= 1'b0;
        end else begin
            rd_vld <= req_vld;
            rd_neg <= is_negative(req_phase);
`ifdef NCO_COS_OUT_EN
            rd_cneg <= is_negative(cos_phase);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            Dout <= '0;
            Dvld <= 1'b0;
`ifdef NCO_COS_OUT_EN
            Cout <= '0;
`endif
        end else if (!En) begin
            Dvld <= 1'b0;
        end else begin
            Dvld <= rd_vld;
            if (rd_vld) begin
                Dout <= rd_neg ? ('0 - rom_sin) : rom_sin;
`ifdef NCO_COS_OUT_EN
                Cout <= rd_cneg ? ('0 - rom_cos) : rom_cos;
`endif
            end
        end
    end

endmodule

// File: tb/tb_nco_phase_to_sine.sv
// tb_nco_phase_to_sine: directed and random beat streams checked cycle by
// cycle against a sample-schedule model computed from sin() directly.
// Macro: NCO_COS_OUT_EN also checks Cout.
module tb_nco_phase_to_sine;

    localparam int MAXC = 4096;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       En;
    logic       Vld;
    logic       ISin;
    logic [1:0] Ain;
    logic [7:0] Dout;
    logic       Dvld;
    logic       Err;
`ifdef NCO_COS_OUT_EN
    logic [7:0] Cout;
`endif

    always #5 clk = ~clk;

    nco_phase_to_sine dut (
        .clk   (clk),
        .rst_n (rst_n),
        .En    (En),
        .Vld   (Vld),
        .Ain   (Ain),
        .ISin  (ISin),
        .Dout  (Dout),
        .Dvld  (Dvld),
        .Err   (Err)
`ifdef NCO_COS_OUT_EN
        ,
        .Cout  (Cout)
`endif
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    bit         exp_v [MAXC];
    logic [7:0] exp_s [MAXC];
    logic [7:0] exp_c [MAXC];

    logic [7:0] m_dout;
    logic [7:0] m_cout;
    logic       m_dvld;
    logic       m_err;
    int         beats[$];

    // round(127*sin(2*pi*(p+0.5)/256)), rounded half away from zero.
    function automatic logic [7:0] ref_wave(input int p);
        real x;
        real mag;
        int  r;
        x   = 127.0 * $sin(2.0 * 3.14159265358979 * (real'(p % 256) + 0.5) / 256.0);
        mag = (x < 0.0) ? -x : x;
        r   = $rtoi(mag + 0.5);
        if (x < 0.0) r = -r;
        return 8'(r);
    endfunction

    task automatic model_edge();
        int p;
        m_err = 1'b0;
        if (!rst_n) begin
            beats.delete();
            m_dout = '0;
            m_cout = '0;
            exp_v[cyc] = 1'b0;
            exp_v[cyc+1] = 1'b0;
        end else if (!En) begin
            beats.delete();
            exp_v[cyc] = 1'b0;
            exp_v[cyc+1] = 1'b0;
        end else if (Vld) begin
            if (ISin) begin
                if (beats.size() > 0) m_err = 1'b1;
                beats.delete();
                beats.push_back(int'(Ain));
            end else if (beats.size() == 0) begin
                m_err = 1'b1;
            end else begin
                beats.push_back(int'(Ain));
                if (beats.size() == 4) begin
                    p = beats[0] * 64 + beats[1] * 16 + beats[2] * 4 + beats[3];
                    exp_v[cyc+2] = 1'b1;
                    exp_s[cyc+2] = ref_wave(p);
                    exp_c[cyc+2] = ref_wave(p + 64);
                    beats.delete();
                end
            end
        end
        m_dvld = exp_v[cyc];
        if (m_dvld) begin
            m_dout = exp_s[cyc];
            m_cout = exp_c[cyc];
        end
        cyc++;
    endtask

    task automatic check_all();
        vectors++;
        assert (Dvld === m_dvld) else begin
            miscompares++;
            $error("FAIL dvld cyc=%0d observed=%b expected=%b", cyc, Dvld, m_dvld);
        end
        vectors++;
        assert (Err === m_err) else begin
            miscompares++;
            $error("FAIL err cyc=%0d observed=%b expected=%b", cyc, Err, m_err);
        end
        vectors++;
        assert (Dout === m_dout) else begin
            miscompares++;
            $error("FAIL dout cyc=%0d observed=%h expected=%h", cyc, Dout, m_dout);
        end
`ifdef NCO_COS_OUT_EN
        vectors++;
        assert (Cout === m_cout) else begin
            miscompares++;
            $error("FAIL cout cyc=%0d observed=%h expected=%h", cyc, Cout, m_cout);
        end
`endif
    endtask

    task automatic check_const(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step(input logic en, input logic vld, input logic isin, input logic [1:0] ain);
        En   = en;
        Vld  = vld;
        ISin = isin;
        Ain  = ain;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 2'b00);
    endtask

    task automatic send_word(input logic [7:0] w);
        logic [7:0] t;
        t = w;
        step(1'b1, 1'b1, 1'b1, t[7:6]);
        step(1'b1, 1'b1, 1'b0, t[5:4]);
        step(1'b1, 1'b1, 1'b0, t[3:2]);
        step(1'b1, 1'b1, 1'b0, t[1:0]);
    endtask

    initial begin
        logic [7:0] w;

        // Reset and idle
        rst_n = 1'b0;
        step(1'b1, 1'b0, 1'b0, 2'b00);
        step(1'b1, 1'b0, 1'b0, 2'b00);
        rst_n = 1'b1;
        idle(3);
        check_const("reset_dout", Dout, 8'h00);

        // Single word 0x40: sample two edges after the last beat
        send_word(8'h40);
        idle(2);
        check_const("w40_dvld", {7'b0, Dvld}, 8'h01);
        check_const("w40_dout", Dout, 8'h7F);
`ifdef NCO_COS_OUT_EN
        check_const("w40_cout", Cout, 8'hFE);
`endif
        idle(2);

        // Half-rate stream, back to back
        send_word(8'h00);
        send_word(8'h80);
        send_word(8'h00);
        send_word(8'h80);
        idle(2);
        check_const("half_last", Dout, 8'hFE);
        idle(2);

        // 0xC0 with a 3-cycle gap between beats 2 and 3
        step(1'b1, 1'b1, 1'b1, 2'b11);
        step(1'b1, 1'b1, 1'b0, 2'b00);
        idle(3);
        step(1'b1, 1'b1, 1'b0, 2'b00);
        step(1'b1, 1'b1, 1'b0, 2'b00);
        idle(2);
        check_const("wc0_dout", Dout, 8'h81);
        idle(2);

        // Restart on beat 3, then the new word completes
        step(1'b1, 1'b1, 1'b1, 2'b10);
        step(1'b1, 1'b1, 1'b0, 2'b01);
        send_word(8'h25);
        idle(3);

        // Stray beat in idle
        step(1'b1, 1'b1, 1'b0, 2'b11);
        idle(3);

        // Restart colliding with a completed word still in the pipeline
        send_word(8'h9A);
        step(1'b1, 1'b1, 1'b1, 2'b01);
        step(1'b1, 1'b1, 1'b1, 2'b00);
        step(1'b1, 1'b1, 1'b0, 2'b00);
        step(1'b1, 1'b1, 1'b0, 2'b00);
        step(1'b1, 1'b1, 1'b0, 2'b00);
        idle(3);

        // Enable drop after beat 2, then a fresh word 0x00
        step(1'b1, 1'b1, 1'b1, 2'b01);
        step(1'b1, 1'b1, 1'b0, 2'b10);
        step(1'b0, 1'b1, 1'b0, 2'b11);
        step(1'b0, 1'b0, 1'b0, 2'b00);
        idle(2);
        send_word(8'h00);
        idle(2);
        check_const("en_fresh", Dout, 8'h02);

        // Enable drop mid-pipeline
        send_word(8'h33);
        step(1'b0, 1'b0, 1'b0, 2'b00);
        idle(3);

        // Random well-formed words with random gaps
        for (int n = 0; n < 40; n++) begin
            w = 8'($urandom_range(0, 255));
            step(1'b1, 1'b1, 1'b1, w[7:6]);
            for (int b = 2; b >= 0; b--) begin
                while ($urandom_range(0, 3) == 0) step(1'b1, 1'b0, 1'b0, 2'($urandom_range(0, 3)));
                step(1'b1, 1'b1, 1'b0, 2'((w >> (2 * b)) & 8'h03));
            end
        end

        // Fully random traffic including restarts, strays and enable drops
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 4) == 0), 2'($urandom_range(0, 3)));
        end
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
